awb_gain_ctrl: RTL
==================

Name: awb_gain_ctrl

Overview:
- Frame-level auto-white-balance controller that sequences the white-balance gain datapath.
- Taps the same 2x2 Bayer quad stream that feeds the gain stage and accumulates per-channel sums over each frame.
- After each frame, computes gray-world R/B gains with a shared serial divider.
- Presents R_gain/G_gain/B_gain/wb_en to the gain stage, changing them only at frame start. Manual gains bypass the computation.

Parameters:
- DW_IN, 10, pixel width; data_in carries 4 pixels.
- DW_GAIN, 10, gain width, unsigned fixed point.
- DW_DEC, 8, fractional bits of gain; unity = 1<<DW_DEC.
- DW_ACC, 32, per-channel accumulator width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- CFA  in  2  Bayer phase of the quad.
- awb_en  in  1  1 = auto gains, 0 = manual gains.
- vsync_in  in  1  high during active frame.
- hsync_in  in  1  high = data_in quad valid this cycle.
- data_in  in  DW_IN*4  quad {p11,p12,p21,p22}, MSB first.
- man_R_gain, man_G_gain, man_B_gain  in  DW_GAIN each  manual gains.
- R_gain, G_gain, B_gain  out  DW_GAIN each  gains to the gain stage, registered.
- wb_en  out  1  gain-stage enable, registered.
- gain_upd  out  1  one-cycle pulse when outputs reload.
- busy  out  1  high in DIV_R/DIV_B.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - R_gain = G_gain = B_gain = 1<<DW_DEC (256).
  - wb_en = 1, gain_upd = 0, busy = 0.
  - Accumulators and pending registers = 0, pend_vld = 0, state = IDLE.
- Frame edges: vs_d is registered vsync_in. rise = vsync_in & ~vs_d; fall = ~vsync_in & vs_d.
- CFA mapping for {p11,p12,p21,p22}:
  - 00 = G,R,B,G
  - 01 = R,G,G,B
  - 10 = B,G,G,R
  - 11 = G,B,R,G
- Accumulation, per valid quad: Rsum += R, Bsum += B, Gsum += G1 + G2. Each add saturates at all-ones of DW_ACC.
- FSM states:
  - IDLE: wait for rise.
  - ACCUM: entered on rise. Accumulators load with this cycle's quad if hsync_in is high, else 0. Accumulate while vsync is high. On fall, go to DIV_R.
  - DIV_R: compute R_p = floor(Gsum*2^DW_DEC / (2*Rsum)). Exactly DW_GAIN+1 cycles: 1 overflow-check cycle, then DW_GAIN restoring-division iterations. Then go to DIV_B.
  - DIV_B: same computation for B_p using Bsum. Then go to PEND with pend_vld = 1.
  - PEND: hold pending gains until rise.
- Divider saturation: if the denominator is 0, or the quotient is >= 2^DW_GAIN, the pending gain = {DW_GAIN{1'b1}}.
- Gsum == 0: pend_vld stays 0; gains are not updated for that frame.
- Gain reload: on every rise (from any state), if awb_en = 1 and pend_vld = 1:
  - R_gain <= R_p, B_gain <= B_p, G_gain <= 1<<DW_DEC.
  - gain_upd = 1 for the next cycle; pend_vld cleared.
- Manual mode: on every rise with awb_en = 0, gains <= man_* and gain_upd pulses. Accumulation and division still run, but the results are discarded.
- Gains never change except on a rise.
- Aborted division: a rise during DIV_R/DIV_B aborts the division, discards partial results, keeps the current gains and enters ACCUM for the new frame.
- Repeated fall while in PEND: overwrites the pending gains with a fresh computation.
- Latency: from the fall cycle to pend_vld is 2*(DW_GAIN+1) cycles (22 at defaults).
- wb_en: 1 after reset and stays 1; it is a register reserved for future bypass.
- Reset mid-division: all state returns to the reset values immediately.

Test Plan:
- Reset, then no frames -> R/G/B_gain = 256, wb_en = 1, gain_upd = 0.
- Gray frame, CFA = 01, 4 quads R=G=G=B=100, awb_en = 1 -> after fall, busy for 22 cycles. At next rise: R_gain = B_gain = G_gain = 256 and gain_upd pulses once.
- Tinted frame, CFA = 01, 4 quads R=100, G=200, B=50 -> Rsum = 400, Gsum = 1600, Bsum = 200. Next rise: R_gain = 512, B_gain = 1023 (saturated, true 1024).
- Same tinted pixels, CFA = 10 (order B,G,G,R) -> identical gains, confirming the CFA mapping.
- Frame with R = 0 everywhere, G = 200, B = 200 -> R_gain = 1023, B_gain = 256. Frame with G = 0 -> gains unchanged, no gain_upd.
- Vertical blank shorter than 22 cycles -> division aborted, gains unchanged. awb_en = 0 with man gains 300/256/400 -> exactly those gains at next rise. Assert rst_n low mid-DIV_B -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/awb_gain_ctrl.sv
// Frame-level auto-white-balance controller: per-frame Bayer channel sums,
// gray-world R/B gains from one shared serial divider, and gain reload at frame start.
module awb_gain_ctrl #(
  parameter int DW_IN   = 10,
  parameter int DW_GAIN = 10,
  parameter int DW_DEC  = 8,
  parameter int DW_ACC  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           CFA,
  input  logic                 awb_en,
  input  logic                 vsync_in,
  input  logic                 hsync_in,
  input  logic [DW_IN*4-1:0]   data_in,
  input  logic [DW_GAIN-1:0]   man_R_gain,
  input  logic [DW_GAIN-1:0]   man_G_gain,
  input  logic [DW_GAIN-1:0]   man_B_gain,
  output logic [DW_GAIN-1:0]   R_gain,
  output logic [DW_GAIN-1:0]   G_gain,
  output logic [DW_GAIN-1:0]   B_gain,
  output logic                 wb_en,
  output logic                 gain_upd,
  output logic                 busy
);

  localparam int WW = DW_ACC + DW_DEC + DW_GAIN + 2;
  localparam int CW = $clog2(DW_GAIN + 1);
  localparam logic [DW_GAIN-1:0] UNITY = DW_GAIN'(32'd1 << DW_DEC);
  localparam logic [DW_GAIN-1:0] GMAX  = {DW_GAIN{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DIV_R = 3'd2,
    DIV_B = 3'd3,
    PEND  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                vs_q, vs_d;
  logic [DW_ACC-1:0]   rsum_q, rsum_d, gsum_q, gsum_d, bsum_q, bsum_d;
  logic [WW-1:0]       rem_q, rem_d;
  logic [DW_GAIN-1:0]  quo_q, quo_d;
  logic                sat_q, sat_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW_GAIN-1:0]  pend_r_q, pend_r_d, pend_b_q, pend_b_d;
  logic                pend_vld_q, pend_vld_d;
  logic [DW_GAIN-1:0]  r_gain_q, r_gain_d, g_gain_q, g_gain_d, b_gain_q, b_gain_d;
  logic                wb_en_q, wb_en_d, gain_upd_q, gain_upd_d, busy_q, busy_d;

  logic                rise_s, fall_s;
  logic [DW_IN-1:0]    p11_s, p12_s, p21_s, p22_s, pr_s, pb_s;
  logic [DW_IN:0]      pg_s;
  logic [WW-1:0]       num_s, den_s, trial_s;
  logic [CW-1:0]       shift_s;
  logic                ge_s, ovf_s;
  logic [DW_GAIN-1:0]  quo_next_s, res_s;

  function automatic logic [DW_ACC-1:0] sat_add(input logic [DW_ACC-1:0] acc,
                                                input logic [DW_IN:0]    val);
    logic [DW_ACC:0] sum;
    sum = {1'b0, acc} + {{(DW_ACC-DW_IN){1'b0}}, val};
    if (sum[DW_ACC]) sat_add = {DW_ACC{1'b1}};
    else             sat_add = sum[DW_ACC-1:0];
  endfunction

  assign rise_s = vsync_in & ~vs_q;
  assign fall_s = ~vsync_in & vs_q;
  assign p11_s  = data_in[4*DW_IN-1 -: DW_IN];
  assign p12_s  = data_in[3*DW_IN-1 -: DW_IN];
  assign p21_s  = data_in[2*DW_IN-1 -: DW_IN];
  assign p22_s  = data_in[DW_IN-1:0];

  // Bayer phase decode of the quad into R, B and the sum of both greens
  always_comb begin
    pr_s = p11_s;
    pb_s = p22_s;
    pg_s = {1'b0, p12_s} + {1'b0, p21_s};
    case (CFA)
      2'b00: begin pr_s = p12_s; pb_s = p21_s; pg_s = {1'b0, p11_s} + {1'b0, p22_s}; end
      2'b01: begin pr_s = p11_s; pb_s = p22_s; pg_s = {1'b0, p12_s} + {1'b0, p21_s}; end
      2'b10: begin pr_s = p22_s; pb_s = p11_s; pg_s = {1'b0, p12_s} + {1'b0, p21_s}; end
      2'b11: begin pr_s = p21_s; pb_s = p12_s; pg_s = {1'b0, p11_s} + {1'b0, p22_s}; end
      default: begin pr_s = p11_s; pb_s = p22_s; pg_s = {1'b0, p12_s} + {1'b0, p21_s}; end
    endcase
  end

  // Shared divider datapath: quotient = Gsum*2^DW_DEC / (2*chan_sum), bits MSB first
  always_comb begin
    num_s = WW'(gsum_q) << DW_DEC;
    if (state_q == DIV_R) den_s = WW'({rsum_q, 1'b0});
    else                  den_s = WW'({bsum_q, 1'b0});
    ovf_s      = (den_s == {WW{1'b0}}) || (num_s >= (den_s << DW_GAIN));
    shift_s    = CW'(DW_GAIN) - cnt_q;
    trial_s    = den_s << shift_s;
    ge_s       = (rem_q >= trial_s);
    quo_next_s = quo_q | ({{(DW_GAIN-1){1'b0}}, ge_s} << shift_s);
    if (sat_q) res_s = GMAX;
    else       res_s = quo_next_s;
  end

  // Next-state logic for the frame FSM, accumulators, divider and gain registers
  always_comb begin
    state_d    = state_q;
    vs_d       = vsync_in;
    rsum_d     = rsum_q;
    gsum_d     = gsum_q;
    bsum_d     = bsum_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    sat_d      = sat_q;
    cnt_d      = cnt_q;
    pend_r_d   = pend_r_q;
    pend_b_d   = pend_b_q;
    pend_vld_d = pend_vld_q;
    r_gain_d   = r_gain_q;
    g_gain_d   = g_gain_q;
    b_gain_d   = b_gain_q;
    wb_en_d    = 1'b1;
    gain_upd_d = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      ACCUM: begin
        if (fall_s) begin
          state_d    = DIV_R;
          cnt_d      = {CW{1'b0}};
          pend_vld_d = 1'b0;
        end else if (vsync_in && hsync_in) begin
          rsum_d = sat_add(rsum_q, {1'b0, pr_s});
          gsum_d = sat_add(gsum_q, pg_s);
          bsum_d = sat_add(bsum_q, {1'b0, pb_s});
        end else begin
          state_d = ACCUM;
        end
      end
      DIV_R, DIV_B: begin
        if (cnt_q == {CW{1'b0}}) begin
          rem_d = num_s;
          quo_d = {DW_GAIN{1'b0}};
          sat_d = ovf_s;
          cnt_d = CW'(1);
        end else begin
          if (ge_s) rem_d = rem_q - trial_s;
          else      rem_d = rem_q;
          quo_d = quo_next_s;
          if (cnt_q == CW'(DW_GAIN)) begin
            cnt_d = {CW{1'b0}};
            if (state_q == DIV_R) begin
              pend_r_d = res_s;
              state_d  = DIV_B;
            end else begin
              pend_b_d   = res_s;
              pend_vld_d = (gsum_q != {DW_ACC{1'b0}});
              state_d    = PEND;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PEND: begin
        if (fall_s) begin
          state_d    = DIV_R;
          cnt_d      = {CW{1'b0}};
          pend_vld_d = 1'b0;
        end else begin
          state_d = PEND;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start wins over everything: restart accumulation and reload gains
    if (rise_s) begin
      state_d = ACCUM;
      cnt_d   = {CW{1'b0}};
      if (hsync_in) begin
        rsum_d = {{(DW_ACC-DW_IN){1'b0}}, pr_s};
        gsum_d = {{(DW_ACC-DW_IN-1){1'b0}}, pg_s};
        bsum_d = {{(DW_ACC-DW_IN){1'b0}}, pb_s};
      end else begin
        rsum_d = {DW_ACC{1'b0}};
        gsum_d = {DW_ACC{1'b0}};
        bsum_d = {DW_ACC{1'b0}};
      end
      if (!awb_en) begin
        r_gain_d   = man_R_gain;
        g_gain_d   = man_G_gain;
        b_gain_d   = man_B_gain;
        gain_upd_d = 1'b1;
      end else if (pend_vld_q) begin
        r_gain_d   = pend_r_q;
        g_gain_d   = UNITY;
        b_gain_d   = pend_b_q;
        gain_upd_d = 1'b1;
      end else begin
        gain_upd_d = 1'b0;
      end
      pend_vld_d = 1'b0;
    end else begin
      state_d = state_d;
    end

    busy_d = (state_d == DIV_R) || (state_d == DIV_B);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vs_q       <= 1'b0;
      rsum_q     <= {DW_ACC{1'b0}};
      gsum_q     <= {DW_ACC{1'b0}};
      bsum_q     <= {DW_ACC{1'b0}};
      rem_q      <= {WW{1'b0}};
      quo_q      <= {DW_GAIN{1'b0}};
      sat_q      <= 1'b0;
      cnt_q      <= {CW{1'b0}};
      pend_r_q   <= {DW_GAIN{1'b0}};
      pend_b_q   <= {DW_GAIN{1'b0}};
      pend_vld_q <= 1'b0;
      r_gain_q   <= UNITY;
      g_gain_q   <= UNITY;
      b_gain_q   <= UNITY;
      wb_en_q    <= 1'b1;
      gain_upd_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs_d;
      rsum_q     <= rsum_d;
      gsum_q     <= gsum_d;
      bsum_q     <= bsum_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      sat_q      <= sat_d;
      cnt_q      <= cnt_d;
      pend_r_q   <= pend_r_d;
      pend_b_q   <= pend_b_d;
      pend_vld_q <= pend_vld_d;
      r_gain_q   <= r_gain_d;
      g_gain_q   <= g_gain_d;
      b_gain_q   <= b_gain_d;
      wb_en_q    <= wb_en_d;
      gain_upd_q <= gain_upd_d;
      busy_q     <= busy_d;
    end
  end

  assign R_gain   = r_gain_q;
  assign G_gain   = g_gain_q;
  assign B_gain   = b_gain_q;
  assign wb_en    = wb_en_q;
  assign gain_upd = gain_upd_q;
  assign busy     = busy_q;

endmodule
